// File: rtl/alu_ctrl_stage.sv
// Purpose : decode RISC-V opcode/funct fields into the ALU control code and datapath
//           control bits, registered at the ID/EX boundary; counts rejected encodings.
// Latency : 1 cycle from decode inputs to outputs. No combinational input->output path.
// Backpressure: stall_i holds the whole stage (outputs and counter); flush_i overrides stall.
//
// Ports:
//   clk_i, rst_i (sync, active-low)        clock and reset
//   valid_i, stall_i, flush_i              pipeline control
//   opcode_i[6:0], funct3_i[2:0], funct7_i[6:0]  instruction fields
//   valid_o, ALUCtrl_o[3:0]                stage valid and ALU control code
//   alusrc_o, regwrite_o, memread_o, memwrite_o, memtoreg_o, branch_o  datapath controls
//   illegal_o, illegal_cnt_o[7:0]          rejected-instruction flag and saturating count
module alu_ctrl_stage (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic       stall_i,
    input  logic       flush_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic       valid_o,
    output logic [3:0] ALUCtrl_o,
    output logic       alusrc_o,
    output logic       regwrite_o,
    output logic       memread_o,
    output logic       memwrite_o,
    output logic       memtoreg_o,
    output logic       branch_o,
    output logic       illegal_o,
    output logic [7:0] illegal_cnt_o
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_XOR  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_MUL  = 4'b0101;
    localparam logic [3:0] ALU_ADDI = 4'b0110;
    localparam logic [3:0] ALU_SRAI = 4'b0111;
    localparam logic [3:0] ALU_LW   = 4'b1000;
    localparam logic [3:0] ALU_SW   = 4'b1001;
    localparam logic [3:0] ALU_BEQ  = 4'b1010;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [3:0] alu;
        logic       alusrc;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       branch;
    } ctrl_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // A bubble drives the BEQ code so the ALU result is 0 (equal-compare on zeroed operands).
    localparam ctrl_t BUBBLE = '{alu: ALU_BEQ, default: 1'b0};

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       illegal_q, illegal_d;
    logic [7:0] cnt_q, cnt_d;

    ctrl_t      dec_ctrl;
    logic       dec_legal;

    // Pure decode of the instruction fields; legality is independent of valid_i.
    always_comb begin
        dec_ctrl  = BUBBLE;
        dec_legal = 1'b0;
        case (opcode_i)
            OP_R: begin
                dec_ctrl.regwrite = 1'b1;
                if (funct7_i == 7'b0000000) begin
                    dec_legal = 1'b1;
                    case (funct3_i)
                        3'b111:  dec_ctrl.alu = ALU_AND;
                        3'b100:  dec_ctrl.alu = ALU_XOR;
                        3'b001:  dec_ctrl.alu = ALU_SLL;
                        3'b000:  dec_ctrl.alu = ALU_ADD;
                        default: dec_legal    = 1'b0;
                    endcase
                end else if (funct7_i == 7'b0100000 && funct3_i == 3'b000) begin
                    dec_legal    = 1'b1;
                    dec_ctrl.alu = ALU_SUB;
                end else if (funct7_i == 7'b0000001 && funct3_i == 3'b000) begin
                    dec_legal    = 1'b1;
                    dec_ctrl.alu = ALU_MUL;
                end
            end
            OP_I: begin
                dec_ctrl.alusrc   = 1'b1;
                dec_ctrl.regwrite = 1'b1;
                if (funct3_i == 3'b000) begin
                    dec_legal    = 1'b1;
                    dec_ctrl.alu = ALU_ADDI;
                end else if (funct3_i == 3'b101 && funct7_i == 7'b0100000) begin
                    dec_legal    = 1'b1;
                    dec_ctrl.alu = ALU_SRAI;
                end
            end
            OP_LOAD: begin
                if (funct3_i == 3'b010) begin
                    dec_legal         = 1'b1;
                    dec_ctrl.alu      = ALU_LW;
                    dec_ctrl.alusrc   = 1'b1;
                    dec_ctrl.regwrite = 1'b1;
                    dec_ctrl.memread  = 1'b1;
                    dec_ctrl.memtoreg = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3_i == 3'b010) begin
                    dec_legal         = 1'b1;
                    dec_ctrl.alu      = ALU_SW;
                    dec_ctrl.alusrc   = 1'b1;
                    dec_ctrl.memwrite = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3_i == 3'b000) begin
                    dec_legal       = 1'b1;
                    dec_ctrl.alu    = ALU_BEQ;
                    dec_ctrl.branch = 1'b1;
                end
            end
            default: dec_legal = 1'b0;
        endcase
        // Partial decodes of illegal encodings must not leak control bits.
        if (!dec_legal) begin
            dec_ctrl = BUBBLE;
        end
    end

    // Next-state / next-output logic, priority flush > stall > empty > legal > illegal.
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        if (flush_i) begin
            state_d   = EMPTY;
            ctrl_d    = BUBBLE;
            illegal_d = 1'b0;
        end else if (stall_i) begin
            // hold everything
        end else if (!valid_i) begin
            state_d   = EMPTY;
            ctrl_d    = BUBBLE;
            illegal_d = 1'b0;
        end else if (dec_legal) begin
            state_d   = FULL;
            ctrl_d    = dec_ctrl;
            illegal_d = 1'b0;
        end else begin
            state_d   = EMPTY;
            ctrl_d    = BUBBLE;
            illegal_d = 1'b1;
            cnt_d     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= EMPTY;
            ctrl_q    <= BUBBLE;
            illegal_q <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign valid_o       = (state_q == FULL);
    assign ALUCtrl_o     = ctrl_q.alu;
    assign alusrc_o      = ctrl_q.alusrc;
    assign regwrite_o    = ctrl_q.regwrite;
    assign memread_o     = ctrl_q.memread;
    assign memwrite_o    = ctrl_q.memwrite;
    assign memtoreg_o    = ctrl_q.memtoreg;
    assign branch_o      = ctrl_q.branch;
    assign illegal_o     = illegal_q;
    assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage: reset, decode sweep, stall, flush, illegal, saturation.
// Outputs are sampled 1 time unit after each rising edge; inputs change right after sampling.
// All outputs are compared as one packed vector {valid, alu, 6 ctrl bits, illegal, count}.
module tb_alu_ctrl_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;

    logic       valid_o;
    logic [3:0] alu_o;
    logic       alusrc_o, regwrite_o, memread_o, memwrite_o, memtoreg_o, branch_o;
    logic       illegal_o;
    logic [7:0] cnt_o;

    int checks = 0;
    int errors = 0;

    alu_ctrl_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .valid_i       (valid),
        .stall_i       (stall),
        .flush_i       (flush),
        .opcode_i      (opcode),
        .funct3_i      (funct3),
        .funct7_i      (funct7),
        .valid_o       (valid_o),
        .ALUCtrl_o     (alu_o),
        .alusrc_o      (alusrc_o),
        .regwrite_o    (regwrite_o),
        .memread_o     (memread_o),
        .memwrite_o    (memwrite_o),
        .memtoreg_o    (memtoreg_o),
        .branch_o      (branch_o),
        .illegal_o     (illegal_o),
        .illegal_cnt_o (cnt_o)
    );

    always #5 clk = ~clk;

    // ctrl ordering: {alusrc, regwrite, memread, memwrite, memtoreg, branch}
    localparam logic [5:0] C_R   = 6'b010000;
    localparam logic [5:0] C_I   = 6'b110000;
    localparam logic [5:0] C_LW  = 6'b111010;
    localparam logic [5:0] C_SW  = 6'b100100;
    localparam logic [5:0] C_BEQ = 6'b000001;

    function automatic logic [19:0] ev(input logic v, input logic [3:0] a, input logic [5:0] c,
                                       input logic ill, input logic [7:0] n);
        return {v, a, c, ill, n};
    endfunction

    function automatic logic [19:0] bubble(input logic ill, input logic [7:0] n);
        return {1'b0, 4'b1010, 6'b000000, ill, n};
    endfunction

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    task automatic step_check(input string tag, input logic [19:0] exp);
        logic [19:0] obs;
        @(posedge clk);
        #1;
        obs = {valid_o, alu_o, alusrc_o, regwrite_o, memread_o, memwrite_o,
               memtoreg_o, branch_o, illegal_o, cnt_o};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Sweep table: AND XOR SLL ADD SUB MUL ADDI SRAI LW SW BEQ
    logic [6:0] sw_op [11];
    logic [2:0] sw_f3 [11];
    logic [6:0] sw_f7 [11];
    logic [5:0] sw_c  [11];

    initial begin
        sw_op = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
                  7'b0010011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
        sw_f3 = '{3'b111, 3'b100, 3'b001, 3'b000, 3'b000, 3'b000,
                  3'b000, 3'b101, 3'b010, 3'b010, 3'b000};
        sw_f7 = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h01,
                  7'h00, 7'h20, 7'h00, 7'h00, 7'h00};
        sw_c  = '{C_R, C_R, C_R, C_R, C_R, C_R, C_I, C_I, C_LW, C_SW, C_BEQ};

        // Reset held 2 cycles with a valid ADD present
        rst = 1'b0; valid = 1'b1; set_in(7'b0110011, 3'b000, 7'h00);
        step_check("reset_cyc1", bubble(1'b0, 8'd0));
        step_check("reset_cyc2", bubble(1'b0, 8'd0));
        rst = 1'b1;
        step_check("post_reset_add", ev(1'b1, 4'b0011, C_R, 1'b0, 8'd0));

        // Full decode sweep back to back
        for (int i = 0; i < 11; i++) begin
            set_in(sw_op[i], sw_f3[i], sw_f7[i]);
            step_check($sformatf("sweep_%0d", i), ev(1'b1, 4'(i), sw_c[i], 1'b0, 8'd0));
        end

        // ADDI ignores funct7; valid_i=0 ignores decode inputs
        set_in(7'b0010011, 3'b000, 7'h7F);
        step_check("addi_any_f7", ev(1'b1, 4'b0110, C_I, 1'b0, 8'd0));
        valid = 1'b0; set_in(7'b0110011, 3'b000, 7'h00);
        step_check("invalid_bubble", bubble(1'b0, 8'd0));
        valid = 1'b1;

        // Stall hold: SUB then 3 stalled cycles with MUL presented
        set_in(7'b0110011, 3'b000, 7'h20);
        step_check("stall_load_sub", ev(1'b1, 4'b0100, C_R, 1'b0, 8'd0));
        stall = 1'b1; set_in(7'b0110011, 3'b000, 7'h01);
        for (int i = 0; i < 3; i++) begin
            step_check($sformatf("stall_hold_%0d", i), ev(1'b1, 4'b0100, C_R, 1'b0, 8'd0));
        end
        stall = 1'b0;
        step_check("stall_release_mul", ev(1'b1, 4'b0101, C_R, 1'b0, 8'd0));

        // Flush beats stall; illegal opcode during flush does not count
        set_in(7'b0100011, 3'b010, 7'h00);
        step_check("flush_load_sw", ev(1'b1, 4'b1001, C_SW, 1'b0, 8'd0));
        flush = 1'b1; stall = 1'b1; set_in(7'b1111111, 3'b000, 7'h00);
        step_check("flush_over_stall", bubble(1'b0, 8'd0));
        flush = 1'b0; stall = 1'b0;

        // Illegal R-type: one-cycle flag, count 1
        set_in(7'b0110011, 3'b111, 7'h20);
        step_check("illegal_first", bubble(1'b1, 8'd1));
        valid = 1'b0;
        step_check("illegal_drop", bubble(1'b0, 8'd1));

        // SRAI needs funct7=0100000
        valid = 1'b1; set_in(7'b0010011, 3'b101, 7'h00);
        step_check("srai_bad_f7", bubble(1'b1, 8'd2));
        valid = 1'b0;
        step_check("srai_bad_drop", bubble(1'b0, 8'd2));

        // Illegal then stalled 2 cycles: flag high 3 cycles, counts once
        valid = 1'b1; set_in(7'b0110011, 3'b111, 7'h20);
        step_check("illegal_stall_0", bubble(1'b1, 8'd3));
        stall = 1'b1;
        step_check("illegal_stall_1", bubble(1'b1, 8'd3));
        step_check("illegal_stall_2", bubble(1'b1, 8'd3));
        stall = 1'b0; valid = 1'b0;
        step_check("illegal_stall_end", bubble(1'b0, 8'd3));

        // Saturation from a clean counter
        rst = 1'b0;
        step_check("sat_reset", bubble(1'b0, 8'd0));
        rst = 1'b1; valid = 1'b1; set_in(7'b1111111, 3'b000, 7'h00);
        for (int i = 1; i <= 260; i++) begin
            step_check($sformatf("sat_%0d", i), bubble(1'b1, (i > 255) ? 8'd255 : 8'(i)));
        end
        rst = 1'b0;
        step_check("sat_mid_reset", bubble(1'b0, 8'd0));
        rst = 1'b1;
        step_check("sat_after_reset", bubble(1'b1, 8'd1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Decode-side producer of the ALU control interface. Takes the RISC-V opcode/funct fields of the instruction leaving ID and produces the 4-bit ALU control code plus the datapath control bits. All of these are registered in the ID/EX boundary with stall, flush and bubble handling. Its ALU control output feeds the EX-stage ALU directly. It also keeps a saturating count of illegal encodings for debug.

## Interface
- No parameters; all widths are fixed.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-low reset.
- valid_i  input  1  an instruction is present on the decode inputs.
- stall_i  input  1  hold the stage; outputs and counter unchanged.
- flush_i  input  1  replace the stage contents with a bubble.
- opcode_i  input  7  instruction[6:0].
- funct3_i  input  3  instruction[14:12].
- funct7_i  input  7  instruction[31:25].
- valid_o  output  1  stage holds a legal instruction.
- ALUCtrl_o  output  4  ALU control code (encoding below).
- alusrc_o  output  1  ALU operand 2 comes from the immediate.
- regwrite_o  output  1  write the register file.
- memread_o  output  1  load.
- memwrite_o  output  1  store.
- memtoreg_o  output  1  writeback from memory.
- branch_o  output  1  conditional branch.
- illegal_o  output  1  the stage holds a rejected valid instruction.
- illegal_cnt_o  output  8  saturating count of rejected instructions.

## Operation
- **ALU control encoding (fixed):**
  - AND=0000, XOR=0001, SLL=0010, ADD=0011.
  - SUB=0100, MUL=0101, ADDI=0110, SRAI=0111.
  - LW=1000, SW=1001, BEQ=1010.
  - 1011–1111 are never driven.
- **R-type decode (opcode 0110011):**
  - funct7=0000000: funct3 111 → AND, 100 → XOR, 001 → SLL, 000 → ADD.
  - funct7=0100000 with funct3=000 → SUB.
  - funct7=0000001 with funct3=000 → MUL.
  - Control bits: regwrite=1, all others 0.
- **I-ALU decode (opcode 0010011):**
  - funct3=000 → ADDI, for any funct7.
  - funct3=101 with funct7=0100000 → SRAI.
  - Control bits: alusrc=1, regwrite=1.
- **Load (opcode 0000011):** funct3=010 → LW. Control bits: alusrc, regwrite, memread, memtoreg all 1.
- **Store (opcode 0100011):** funct3=010 → SW. Control bits: alusrc=1, memwrite=1.
- **Branch (opcode 1100011):** funct3=000 → BEQ. Control bits: branch=1.
- **Illegal:** any other opcode/funct combination with valid_i=1.
- **Bubble contents:**
  - valid_o=0, ALUCtrl_o=1010 (the ALU then outputs 0).
  - All control bits 0, illegal_o=0.
- **Stage state machine.** Two states, derived from the registered outputs:
  - EMPTY: stage holds a bubble (valid_o=0).
  - FULL: stage holds an instruction (valid_o=1).
  - Rejected instructions occupy the stage as a bubble with illegal_o=1.
- **Per-edge priority, highest first:**
  1. rst_i=0 → bubble; illegal_cnt_o=0.
  2. flush_i=1 → bubble. Counter unchanged, even if the incoming instruction is illegal.
  3. stall_i=1 → all outputs and the counter hold.
  4. valid_i=0 → bubble.
  5. valid_i=1, legal → load the decoded values; valid_o=1.
  6. valid_i=1, illegal → bubble with illegal_o=1; illegal_cnt_o increments, saturating at 255.
- The counter increments only on a load edge (case 6), never during stall or flush.
- Decode inputs are ignored whenever valid_i=0.

## Timing
- Latency is 1 cycle: decode inputs sampled at edge N appear on the outputs after edge N.
- No combinational path from any input to any output.
- Reset values of all outputs:
  - valid_o=0, ALUCtrl_o=1010.
  - alusrc/regwrite/memread/memwrite/memtoreg/branch = 0.
  - illegal_o=0, illegal_cnt_o=0.
- Reset is sampled only on clock edges. Asserting it mid-stall or mid-flush takes effect at the next edge and overrides both.
- Stall is a pure hold: while stall_i=1 the outputs are bit-identical on every cycle, including illegal_o=1 if it was set. The first non-stalled edge loads the current inputs.
- flush_i and stall_i high together → flush wins; bubble on the next edge.
- illegal_o follows the stage contents. It is high for exactly one cycle unless stalled, and is extended by the stall length.
- Counter saturation: at 255 a further illegal load leaves it at 255. No wrap.

## Test plan
- **Reset:** hold rst_i=0 for 2 cycles with valid_i=1 and an ADD encoding → valid_o=0, ALUCtrl_o=1010, illegal_cnt_o=0. Release: the next edge loads ADD (0011), regwrite_o=1.
- **Full decode sweep**, one instruction per cycle, back to back:
  - AND, XOR, SLL, ADD, SUB, MUL, ADDI, SRAI, LW, SW, BEQ.
  - Expect ALUCtrl_o = 0000…1010 in order, each one cycle after issue, with the control bits listed above.
  - Example: LW → alusrc=regwrite=memread=memtoreg=1.
- **Stall hold:** load SUB, then stall_i=1 for 3 cycles while the inputs change to MUL → ALUCtrl_o stays 0100 for all 3 cycles. Release → 0101 on the next edge.
- **Flush priority:** flush_i=stall_i=1 while holding SW → bubble next cycle (valid_o=0, memwrite_o=0). Counter unchanged with an illegal opcode 1111111 presented.
- **Illegal handling:**
  - opcode 0110011, funct7=0100000, funct3=111 → valid_o=0, illegal_o=1 for one cycle, illegal_cnt_o=1.
  - Same case stalled 2 cycles → illegal_o high for 3 cycles, counter still 1.
- **Saturation:** 260 consecutive illegal instructions → illegal_cnt_o reaches 255 and stays there. Mid-stream reset → 0.
